// File: rtl/battleship_game_fsm.sv
// Keyboard-Battleship game sequencer: ship placement, alternating turns with a
// per-turn forfeit timer, per-player hit counting and winner declaration.
module battleship_game_fsm #(
    parameter int unsigned SHIP_CELLS   = 17,
    parameter int unsigned TURN_TIMEOUT = 500_000_000,
    parameter int unsigned TO_W         = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       place_done,
    input  logic       shot_valid,
    input  logic       shot_hit,
    output logic       shot_ready,
    output logic [2:0] state,
    output logic       active_player,
    output logic [4:0] p1_hits,
    output logic [4:0] p2_hits,
    output logic       turn_timeout
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_P1_SETUP = 3'd1,
        S_P2_SETUP = 3'd2,
        S_P1_TURN  = 3'd3,
        S_P2_TURN  = 3'd4,
        S_P1_WIN   = 3'd5,
        S_P2_WIN   = 3'd6
    } state_e;

    localparam logic [4:0]      SHIP_CELLS_L = 5'(SHIP_CELLS);
    localparam logic [TO_W-1:0] TIMER_LAST   = TO_W'(TURN_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [4:0]      p1_hits_q, p1_hits_d;
    logic [4:0]      p2_hits_q, p2_hits_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic            turn_timeout_q, turn_timeout_d;
    logic            shot_accept;
    logic            timer_expired;
    logic            in_turn;

    // Shot handshake: a shot transfers on any rising edge where shot_valid and
    // shot_ready are both high; shot_hit is only meaningful in that cycle.
    assign in_turn       = (state_q == S_P1_TURN) || (state_q == S_P2_TURN);
    assign shot_ready    = in_turn;
    assign shot_accept   = shot_valid && shot_ready;
    assign timer_expired = (timer_q == TIMER_LAST);

    always_comb begin
        state_d        = state_q;
        p1_hits_d      = p1_hits_q;
        p2_hits_d      = p2_hits_q;
        turn_timeout_d = 1'b0;
        case (state_q)
            S_IDLE, S_P1_WIN, S_P2_WIN: begin
                if (start) begin
                    state_d   = S_P1_SETUP;
                    p1_hits_d = 5'd0;
                    p2_hits_d = 5'd0;
                end
            end
            S_P1_SETUP: if (place_done) state_d = S_P2_SETUP;
            S_P2_SETUP: if (place_done) state_d = S_P1_TURN;
            S_P1_TURN: begin
                if (shot_accept) begin
                    state_d = S_P2_TURN;
                    if (shot_hit) begin
                        p1_hits_d = p1_hits_q + 5'd1;
                        if (p1_hits_d == SHIP_CELLS_L) state_d = S_P1_WIN;
                    end
                end else if (timer_expired) begin
                    state_d        = S_P2_TURN;
                    turn_timeout_d = 1'b1;
                end
            end
            S_P2_TURN: begin
                if (shot_accept) begin
                    state_d = S_P1_TURN;
                    if (shot_hit) begin
                        p2_hits_d = p2_hits_q + 5'd1;
                        if (p2_hits_d == SHIP_CELLS_L) state_d = S_P2_WIN;
                    end
                end else if (timer_expired) begin
                    state_d        = S_P1_TURN;
                    turn_timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every turn change is a state change, so any transition restarts the timer.
    always_comb begin
        if (!in_turn || (state_d != state_q)) timer_d = '0;
        else                                  timer_d = timer_q + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            p1_hits_q      <= 5'd0;
            p2_hits_q      <= 5'd0;
            timer_q        <= '0;
            turn_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            p1_hits_q      <= p1_hits_d;
            p2_hits_q      <= p2_hits_d;
            timer_q        <= timer_d;
            turn_timeout_q <= turn_timeout_d;
        end
    end

    assign state         = state_q;
    assign active_player = (state_q == S_P2_SETUP) || (state_q == S_P2_TURN) ||
                           (state_q == S_P2_WIN);
    assign p1_hits       = p1_hits_q;
    assign p2_hits       = p2_hits_q;
    assign turn_timeout  = turn_timeout_q;

endmodule

// File: tb/tb_battleship_game_fsm.sv
// Bench for battleship_game_fsm: stimulus table, hand-written turn-timer and
// reset sequences, and randomized play checked against a game-level model.
module tb_battleship_game_fsm;

    localparam int SHIP = 3;
    localparam int TO   = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       place_done;
    logic       shot_valid;
    logic       shot_hit;
    logic       shot_ready;
    logic [2:0] state;
    logic       active_player;
    logic [4:0] p1_hits;
    logic [4:0] p2_hits;
    logic       turn_timeout;

    battleship_game_fsm #(
        .SHIP_CELLS  (SHIP),
        .TURN_TIMEOUT(TO),
        .TO_W        (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .place_done   (place_done),
        .shot_valid   (shot_valid),
        .shot_hit     (shot_hit),
        .shot_ready   (shot_ready),
        .state        (state),
        .active_player(active_player),
        .p1_hits      (p1_hits),
        .p2_hits      (p2_hits),
        .turn_timeout (turn_timeout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // game-level reference model: phase 0 idle, 1 setup, 2 turn, 3 won
    int m_phase;
    int m_player;
    int m_hits[2];
    int m_idle;
    int m_pulse;

    function automatic void model_reset();
        m_phase   = 0;
        m_player  = 0;
        m_hits[0] = 0;
        m_hits[1] = 0;
        m_idle    = 0;
        m_pulse   = 0;
    endfunction

    function automatic int model_code();
        case (m_phase)
            0:       return 0;
            1:       return 1 + m_player;
            2:       return 3 + m_player;
            default: return 5 + m_player;
        endcase
    endfunction

    function automatic void model_step(input bit st, input bit pd, input bit sv, input bit sh);
        m_pulse = 0;
        case (m_phase)
            0, 3: if (st) begin
                m_phase = 1; m_player = 0; m_hits[0] = 0; m_hits[1] = 0;
            end
            1: if (pd) begin
                if (m_player == 0) m_player = 1;
                else begin m_phase = 2; m_player = 0; m_idle = 0; end
            end
            default: begin
                if (sv) begin
                    m_idle = 0;
                    if (sh) m_hits[m_player] = m_hits[m_player] + 1;
                    if (sh && m_hits[m_player] == SHIP) m_phase = 3;
                    else m_player = 1 - m_player;
                end else if (m_idle == TO - 1) begin
                    m_idle = 0; m_player = 1 - m_player; m_pulse = 1;
                end else begin
                    m_idle = m_idle + 1;
                end
            end
        endcase
    endfunction

    // scoreboard
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("state", int'(state), model_code());
        chk("active_player", int'(active_player), (m_phase == 0) ? 0 : m_player);
        chk("shot_ready", int'(shot_ready), (m_phase == 2) ? 1 : 0);
        chk("p1_hits", int'(p1_hits), m_hits[0]);
        chk("p2_hits", int'(p2_hits), m_hits[1]);
        chk("turn_timeout", int'(turn_timeout), m_pulse);
    endtask

    // driver: apply inputs for one edge, then sample 1 ns after it
    task automatic cycle(input bit st, input bit pd, input bit sv, input bit sh);
        start      = st;
        place_done = pd;
        shot_valid = sv;
        shot_hit   = sh;
        @(posedge clk);
        #1;
        model_step(st, pd, sv, sh);
        chk_model();
    endtask

    task automatic expect_now(input string name, input int st, input int to, input int p2);
        chk({name, ".state"}, int'(state), st);
        chk({name, ".timeout"}, int'(turn_timeout), to);
        chk({name, ".p2_hits"}, int'(p2_hits), p2);
    endtask

    typedef struct {
        logic       st, pd, sv, sh;
        logic [2:0] e_state;
        logic [4:0] e_p1, e_p2;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[20];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 5'd0, 5'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 5'd0, 5'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 5'd0, 5'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 5'd0, 5'd0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 5'd1, 5'd0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 5'd1, 5'd0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 5'd2, 5'd0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 5'd2, 5'd0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 5'd3, 5'd0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 5'd3, 5'd0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 5'd3, 5'd0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 5'd0, 5'd0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 5'd0, 5'd0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 5'd0, 5'd0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 5'd0, 5'd0, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 5'd0, 5'd0, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 5'd0, 5'd0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 5'd0, 5'd0, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 5'd0, 5'd0, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 5'd0, 5'd1, 1'b1};

        rst_n      = 1'b0;
        start      = 1'b0;
        place_done = 1'b0;
        shot_valid = 1'b0;
        shot_hit   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_model();
        @(negedge clk);
        rst_n = 1'b1;

        // table: setup, P1 win, ignored inputs in each phase
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].st, tbl[i].pd, tbl[i].sv, tbl[i].sh);
            chk($sformatf("tbl%0d.state", i), int'(state), int'(tbl[i].e_state));
            chk($sformatf("tbl%0d.p1", i), int'(p1_hits), int'(tbl[i].e_p1));
            chk($sformatf("tbl%0d.p2", i), int'(p2_hits), int'(tbl[i].e_p2));
            chk($sformatf("tbl%0d.rdy", i), int'(shot_ready), int'(tbl[i].e_rdy));
        end

        // P2 idles out, then P1 idles out on a freshly restarted timer
        cycle(0, 0, 1, 0);
        expect_now("to_enter_p2", 4, 0, 1);
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, 0, 0);
            expect_now("to_p2_wait", 4, 0, 1);
        end
        cycle(0, 0, 0, 0);
        expect_now("to_p2_expire", 3, 1, 1);
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, 0, 0);
            expect_now("to_p1_wait", 3, 0, 1);
        end
        cycle(0, 0, 0, 0);
        expect_now("to_p1_expire", 4, 1, 1);
        // shot in the expiry cycle beats the timeout
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 1);
        expect_now("to_shot_wins", 3, 0, 2);

        // asynchronous reset between edges, mid-turn with p2_hits=2
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_model();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        expect_now("after_reset", 3, 0, 0);

        // P2 wins, then restart from P2_WIN
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0);
            cycle(0, 0, 1, 1);
        end
        expect_now("p2_win", 6, 0, 3);
        chk("p2_win.active", int'(active_player), 1);
        cycle(1, 0, 0, 0);
        expect_now("restart", 1, 0, 0);
        chk("restart.p1", int'(p1_hits), 0);

        // randomized play against the model
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
